// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame sequencer driving the registered TX output mux
module uart_tx_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  data_ready,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [BAUD_W-1:0]       baud_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    par_en_q;
    logic                    accept;
    logic                    bit_end;

    assign accept   = (state == S_IDLE) && data_valid;
    assign bit_end  = (baud_cnt == BAUD_LAST);
    assign ser_data = shift_reg[0];

    // State register; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs (no input reaches an output)
    always_comb begin
        state_next = state;
        mux_sel    = 2'b11;
        data_ready = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                data_ready = 1'b1;
                busy       = 1'b0;
                if (data_valid) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                mux_sel = 2'b00;
                if (bit_end) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                mux_sel = 2'b01;
                if (bit_end && (bit_cnt == BIT_LAST)) begin
                    state_next = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                mux_sel = 2'b10;
                if (bit_end) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    frame_done = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    // Byte/parity capture on accept, baud and bit counting, LSB-first shifting
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '1;
            par_bit   <= 1'b0;
            par_en_q  <= 1'b0;
        end else if (accept) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= p_data;
            par_en_q  <= par_en;
            par_bit   <= par_typ ? ~^p_data : ^p_data;
        end else if (state != S_IDLE) begin
            baud_cnt <= bit_end ? '0 : baud_cnt + BAUD_W'(1);
            if ((state == S_DATA) && bit_end) begin
                shift_reg <= {1'b1, shift_reg[DATA_WIDTH-1:1]};
                bit_cnt   <= bit_cnt + BIT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl against a per-cycle frame model
module tb_uart_tx_ctrl;

    localparam int DW  = 8;
    localparam int CPB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          data_valid;
    logic [DW-1:0] p_data;
    logic          par_en;
    logic          par_typ;
    logic          data_ready;
    logic [1:0]    mux_sel;
    logic          ser_data;
    logic          par_bit;
    logic          busy;
    logic          frame_done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .p_data     (p_data),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .data_ready (data_ready),
        .mux_sel    (mux_sel),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge while idle. Offers the byte, then checks every cycle
    // of the frame against the bit-slot view: slot 0 start, slots 1..DW data,
    // optional parity slot, then stop; each slot is CPB cycles long.
    task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt, input logic hold);
        int         len;
        int         slot;
        logic [1:0] exp_sel;
        logic       exp_par;
        len     = (2 + DW + (pe ? 1 : 0)) * CPB;
        exp_par = logic'($countones(d) % 2) ^ pt;
        check("ready_before_accept", data_ready, 1);
        data_valid = 1'b1;
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= len; k++) begin
            slot = (k - 1) / CPB;
            if (slot == 0)                 exp_sel = 2'b00;
            else if (slot <= DW)           exp_sel = 2'b01;
            else if (pe && slot == DW + 1) exp_sel = 2'b10;
            else                           exp_sel = 2'b11;
            check("mux_sel", mux_sel, exp_sel);
            if (exp_sel == 2'b01) check("ser_data", ser_data, d[slot-1]);
            check("par_bit", par_bit, exp_par);
            check("busy", busy, 1);
            check("data_ready_in_frame", data_ready, 0);
            check("frame_done", frame_done, (k == len));
            if (hold) begin
                p_data  = DW'($urandom);
                par_en  = 1'($urandom);
                par_typ = 1'($urandom);
            end else begin
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("idle_ready", data_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_mux_sel", mux_sel, 2'b11);
        check("idle_frame_done", frame_done, 0);
    endtask

    initial begin
        rst        = 1'b1;
        data_valid = 1'b0;
        p_data     = '0;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mux_sel", mux_sel, 2'b11);
        check("rst_ser_data", ser_data, 1);
        check("rst_par_bit", par_bit, 0);
        check("rst_busy", busy, 0);
        check("rst_data_ready", data_ready, 1);
        check("rst_frame_done", frame_done, 0);
        rst = 1'b0;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("quiet_mux_sel", mux_sel, 2'b11);
            check("quiet_busy", busy, 0);
            check("quiet_frame_done", frame_done, 0);
        end

        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0);

        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);

        data_valid = 1'b1;
        p_data     = 8'h96;
        par_en     = 1'b1;
        par_typ    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (CPB + 2) @(negedge clk);
        check("pre_reset_in_data", mux_sel, 2'b01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_mux_sel", mux_sel, 2'b11);
        check("midrst_busy", busy, 0);
        check("midrst_data_ready", data_ready, 1);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_ser_data", ser_data, 1);
        check("midrst_par_bit", par_bit, 0);
        for (int i = 0; i < 12 * CPB; i++) begin
            @(negedge clk);
            check("after_rst_frame_done", frame_done, 0);
            check("after_rst_mux_sel", mux_sel, 2'b11);
        end

        for (int i = 0; i < 24; i++) begin
            send_frame(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame sequencer for the UART transmitter. It accepts a parallel byte through a valid/ready handshake and latches it with the parity configuration. It then steps the start / data / parity / stop phases at a programmable bit period. It drives the select, serial-data and parity inputs of the registered 4:1 TX output mux, which holds the line high at reset and idle.

## Interface
- DATA_WIDTH, 8: payload bits per frame, 5..9.
- CLKS_PER_BIT, 16: clk cycles per UART bit, ≥2.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- data_valid  in  1  p_data holds a byte to send.
- p_data  in  DATA_WIDTH  payload, sent LSB first.
- par_en  in  1  1 = insert parity bit.
- par_typ  in  1  0 = even, 1 = odd.
- data_ready  out  1  high in IDLE; a transfer happens on a clk edge with data_valid & data_ready.
- mux_sel  out  2  to the TX mux: 00 start, 01 data, 10 parity, 11 stop/idle.
- ser_data  out  1  current data bit (shift register LSB).
- par_bit  out  1  parity of the latched byte.
- busy  out  1  high from the cycle after accept through the last STOP cycle.
- frame_done  out  1  one-cycle pulse on the last STOP cycle.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered or decoded from state/registers only, with no input-to-output combinational path.
- Reset values: state IDLE, mux_sel 11, ser_data 1, par_bit 0, busy 0, data_ready 1, frame_done 0, counters 0.
- **IDLE**
  - mux_sel 11, data_ready 1, busy 0.
  - On accept: latch p_data into the shift register and latch par_en.
  - Compute par_bit = ^p_data (even) or ~^p_data (odd) and hold it for the frame.
  - Clear the baud and bit counters, then go to START.
- **Baud counter** counts 0..CLKS_PER_BIT-1 in every non-IDLE state. The state advances when it reaches CLKS_PER_BIT-1, then it wraps to 0.
- **START**: mux_sel 00 for one bit period, then DATA.
- **DATA**
  - mux_sel 01 for DATA_WIDTH bit periods.
  - At each bit boundary, shift right so ser_data shows the next bit and increment the bit counter.
  - After bit DATA_WIDTH-1: go to PARITY if the latched par_en is 1, else STOP.
- **PARITY**: mux_sel 10 for one bit period, then STOP.
- **STOP**: mux_sel 11 for one bit period. frame_done = 1 on its final cycle, then IDLE.
- Ignored inputs:
  - data_valid while not in IDLE is ignored; there is no queuing and no error flag.
  - Changes to p_data, par_en or par_typ after accept do not affect the frame in flight.
- rst asserted mid-frame: on the next edge the state returns to IDLE and all outputs take their reset values. The frame is abandoned and the line returns high through the mux.

## Timing
- Accept at edge N:
  - START occupies cycles N+1..N+CPB.
  - DATA occupies N+CPB+1..N+(1+DATA_WIDTH)·CPB.
  - PARITY, when enabled, occupies the next CPB cycles.
  - STOP occupies the final CPB cycles.
- Frame length: (2+DATA_WIDTH+par_en)·CPB cycles.
- The TX mux is registered, so the line lags mux_sel by one clk. Relative timing between bits is preserved.
- Back-to-back frames:
  - data_ready rises in the cycle after frame_done.
  - The minimum gap between frames is one IDLE cycle (line high for stop bit + 1 clk).
- The baud and bit counters are sized ceil(log2) of their maxima.
- The final data shift may occur but is don't-care, since ser_data is only sampled while mux_sel = 01.

## Test plan
- Even parity, CPB=4, DATA_WIDTH=8, p_data=8'hA5, par_en=1, par_typ=0, accept at N:
  - mux_sel 00 for N+1..N+4.
  - mux_sel 01 for N+5..N+36, with ser_data bits 1,0,1,0,0,1,0,1 at 4-cycle spacing.
  - mux_sel 10 for N+37..N+40, with par_bit 0.
  - mux_sel 11 for N+41..N+44, with frame_done at N+44.
  - data_ready 1 at N+45.
- Odd parity: p_data=8'h07, par_typ=1, par_en=1 -> par_bit 0. With par_typ=0 -> par_bit 1.
- No parity: par_en=0, CPB=4, p_data=8'hFF -> no mux_sel=10 cycle; frame_done at N+40.
- Input stability:
  - data_valid held high throughout with p_data changed mid-frame -> the second byte is accepted exactly one cycle after frame_done.
  - The first frame's bits are unchanged by the mid-frame p_data change.
  - busy drops for exactly one cycle between frames.
- Mid-frame reset: rst pulsed one cycle during DATA -> the next cycle shows state IDLE, mux_sel 11, busy 0, data_ready 1, and no frame_done.
- Post-reset idle: after reset with data_valid=0 for 100 cycles -> mux_sel stays 11, busy 0, frame_done never asserted.
